var_delay_line: RTL and testbench

Multi-channel, run-time-programmable delay line built on a circular buffer. It is the next generation of the fixed enable-gated register-chain delay used to align feature-map data with kernel and control paths in the CNN datapath. Delay can be changed at run time without resynthesis. A valid bit travels with the data, and a priming counter keeps stale buffer contents from being flagged as valid.

---
 rtl/delay_pkg.sv | 30 +++
 rtl/delay_ring_buf.sv | 46 ++++
 rtl/var_delay_line.sv | 151 +++++++++++++++
 tb/tb_var_delay_line.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared types and helpers for the run-time programmable delay line.
// Width helpers keep the pointer, counter and delay-select sizing in one place.
package delay_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    PRIMED  = 2'd2
  } state_t;

  function automatic int ptr_w(input int max_delay);
    return (max_delay < 2) ? 1 : $clog2(max_delay);
  endfunction

  function automatic int sel_w(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // Zero either selects the bypass (returns 0) or is treated as a one-cycle delay.
  function automatic int clamp_delay(input int sel, input int max_delay, input bit zero_en);
    if (sel == 0) begin
      return zero_en ? 0 : 1;
    end
    if (sel > max_delay) begin
      return max_delay;
    end
    return sel;
  endfunction

endpackage

// File: rtl/delay_ring_buf.sv
// Circular storage for the delay line: one data word plus one valid bit per entry.
// Valid bits can be wiped in one cycle without touching the data words.
module delay_ring_buf
  import delay_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic             clr_valid,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvalid,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_mem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
      end
      valid_mem <= '0;
    end else begin
      if (we) begin
        data_mem[waddr] <= wdata;
      end
      if (clr_valid) begin
        valid_mem <= '0;
      end else if (we) begin
        valid_mem[waddr] <= wvalid;
      end
    end
  end

  assign rdata  = data_mem[raddr];
  assign rvalid = valid_mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// Multi-channel programmable delay line equivalent to a D-stage enable-gated register chain.
// Optional VAR_DELAY_ZERO_EN: delay_sel==0 becomes a combinational bypass instead of D=1.
module var_delay_line
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNELS      = 3,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 12
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [$clog2(MAX_DELAY+1)-1:0] delay_sel,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           primed
);

  localparam int W     = CHANNELS * DATA_WIDTH;
  localparam int PTR_W = ptr_w(MAX_DELAY);
  localparam int SEL_W = sel_w(MAX_DELAY);
  localparam int EXT_W = PTR_W + 1;
`ifdef VAR_DELAY_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif
  localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(MAX_DELAY);
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_DELAY);
  localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_DELAY - 1);
  localparam logic [EXT_W-1:0] MAX_EXT  = EXT_W'(MAX_DELAY);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] wptr_next;
  logic [SEL_W-1:0] fill_cnt;
  logic [SEL_W-1:0] fill_next;
  logic [SEL_W-1:0] delay_q;
  logic [SEL_W-1:0] eff;
  logic [SEL_W-1:0] rd_delay;
  logic             change;
  logic             primed_q;
  logic             primed_next;
  logic [W-1:0]     out_q;
  logic             out_valid_q;
  state_t           state;
  state_t           state_next;
  logic [EXT_W-1:0] rd_ext;
  logic [PTR_W-1:0] rd_idx;
  logic [W-1:0]     rd_data;
  logic             rd_valid;
  logic [W-1:0]     src_data;
  logic             src_valid;

  // The read index carries one extra bit so wptr-D+1 never underflows at wptr=0.
  always_comb begin
    eff       = SEL_W'(clamp_delay(int'(delay_sel), MAX_DELAY, ZERO_EN));
    rd_delay  = (eff == '0) ? ONE_SEL : eff;
    change    = enable && (eff != delay_q);
    wptr_next = (wptr == LAST_PTR) ? '0 : wptr + PTR_W'(1);
    rd_ext    = {1'b0, wptr} + MAX_EXT + EXT_W'(1) - EXT_W'(rd_delay);
    if (rd_ext >= MAX_EXT) begin
      rd_ext = rd_ext - MAX_EXT;
    end
    rd_idx    = rd_ext[PTR_W-1:0];
    src_data  = (rd_delay == ONE_SEL) ? in : rd_data;
    src_valid = (rd_delay == ONE_SEL) ? in_valid : rd_valid;
  end

  // The write on a delay-change edge is deliberately not counted toward priming.
  always_comb begin
    fill_next   = fill_cnt;
    primed_next = primed_q;
    state_next  = state;
    if (flush) begin
      fill_next   = '0;
      primed_next = 1'b0;
      state_next  = EMPTY;
    end else if (enable) begin
      if (change) begin
        fill_next = '0;
      end else if (fill_cnt < MAX_SEL) begin
        fill_next = fill_cnt + SEL_W'(1);
      end
      primed_next = (fill_next >= eff);
      state_next  = primed_next ? PRIMED : FILLING;
    end
  end

  delay_ring_buf #(
    .DEPTH (MAX_DELAY),
    .WIDTH (W),
    .AW    (PTR_W)
  ) u_ring (
    .clk       (clk),
    .resetn    (resetn),
    .we        (enable && !flush),
    .clr_valid (flush),
    .waddr     (wptr),
    .wdata     (in),
    .wvalid    (in_valid),
    .raddr     (rd_idx),
    .rdata     (rd_data),
    .rvalid    (rd_valid)
  );

  // Flush clears history but leaves the last output word in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr        <= '0;
      fill_cnt    <= '0;
      delay_q     <= DEF_SEL;
      primed_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      state       <= EMPTY;
    end else begin
      if (enable) begin
        delay_q <= eff;
      end
      fill_cnt <= fill_next;
      primed_q <= primed_next;
      state    <= state_next;
      if (flush) begin
        wptr        <= '0;
        out_valid_q <= 1'b0;
      end else if (enable) begin
        wptr        <= wptr_next;
        out_q       <= src_data;
        out_valid_q <= src_valid & primed_next;
      end
    end
  end

`ifdef VAR_DELAY_ZERO_EN
  logic bypass;
  assign bypass    = (delay_q == '0);
  assign out       = bypass ? in : out_q;
  assign out_valid = bypass ? in_valid : out_valid_q;
  assign primed    = bypass | primed_q;
`else
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;
`endif

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboard bench for var_delay_line: a history-based gated-chain model predicts every edge.
// Build with +define+VAR_DELAY_ZERO_EN to exercise the combinational bypass.
module tb_var_delay_line;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        flush;
  logic [4:0]  delay_sel;
  logic        in_valid;
  logic [23:0] in_data;
  logic [23:0] out_data;
  logic        out_valid;
  logic        primed;

  var_delay_line #(
    .DATA_WIDTH    (8),
    .CHANNELS      (3),
    .MAX_DELAY     (16),
    .DEFAULT_DELAY (12)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .flush     (flush),
    .delay_sel (delay_sel),
    .in_valid  (in_valid),
    .in        (in_data),
    .out       (out_data),
    .out_valid (out_valid),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          p;
    bit          dk;
    logic [23:0] d;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] hd[$];
  bit          hv[$];
  int          total = 0;
  int          bad   = 0;
  int          md;
  int          cnt;
  int          contig;
  bit          ev;
  bit          ep;
  bit          edk;
  logic [23:0] ed;

  function automatic int clampModel(input int s);
    if (s == 0) begin
`ifdef VAR_DELAY_ZERO_EN
      return 0;
`else
      return 1;
`endif
    end
    return (s > 16) ? 16 : s;
  endfunction

  task automatic resetModel();
    md = 12; cnt = 0; contig = 0;
    ev = 0; ep = 0; edk = 1; ed = '0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge outputs and queue them.
  task automatic applyStimulus(input bit en, input bit fl, input logic [4:0] sel,
                               input bit v, input logic [23:0] d, input string tag);
    int   e;
    bit   chg;
    exp_t x;
    @(negedge clk);
    enable = en; flush = fl; delay_sel = sel; in_valid = v; in_data = d;
    e   = clampModel(int'(sel));
    chg = en && (e != md);
    if (en) md = e;
    if (fl) begin
      cnt = 0; contig = 0; ev = 0; ep = 0;
    end else if (en) begin
      hd.push_back(d);
      hv.push_back(v);
      contig++;
      if (chg) cnt = 0;
      else if (cnt < 16) cnt++;
      ep = (cnt >= md);
      if (md <= 1) begin
        ed = d; edk = 1; ev = v && ep;
      end else begin
        edk = (contig >= md);
        if (edk) ed = hd[hd.size() - md];
        ev = ep && (hv.size() >= md) && hv[hv.size() - md];
      end
    end
    x.v = ev; x.p = ep; x.dk = edk; x.d = ed; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t x;
    x = sb.pop_front();
    total++;
    assert (out_valid === x.v) else begin
      bad++;
      $error("FAIL %s.out_valid got=%b exp=%b", x.tag, out_valid, x.v);
    end
    total++;
    assert (primed === x.p) else begin
      bad++;
      $error("FAIL %s.primed got=%b exp=%b", x.tag, primed, x.p);
    end
    if (x.dk) begin
      total++;
      assert (out_data === x.d) else begin
        bad++;
        $error("FAIL %s.out got=%h exp=%h", x.tag, out_data, x.d);
      end
    end
  endtask

  task automatic checkDirect(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input bit en, input bit fl, input logic [4:0] sel, input string tag);
    applyStimulus(en, fl, sel, 1'($urandom_range(0, 3) != 0), 24'($urandom), tag);
    checkOutput();
  endtask

  initial begin
    clk = 0; resetn = 0; enable = 0; flush = 0; delay_sel = 5'd12;
    in_valid = 0; in_data = '0;
    resetModel();
    #12;
    checkDirect("reset.out", out_data, 24'h000000);
    checkDirect("reset.out_valid", 24'(out_valid), 24'h0);
    checkDirect("reset.primed", 24'(primed), 24'h0);
    @(negedge clk);
    resetn = 1;

    // Default D=12: first valid on the 12th enabled edge carrying the first sample.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 0, 5'd12, 1, 24'(24'h0A0B0C + k), "fill12");
      checkOutput();
      if (k == 10) checkDirect("fill12.early_valid", 24'(out_valid), 24'h0);
    end
    checkDirect("fill12.first_out", out_data, 24'h0A0B0C);
    checkDirect("fill12.first_valid", 24'(out_valid), 24'h1);
    checkDirect("fill12.primed", 24'(primed), 24'h1);

    for (int i = 0; i < 16; i++) step(i % 2 == 0, 0, 5'd3, "gate3");

    for (int i = 0; i < 8; i++) step(1, 0, 5'd5, "d5");
    for (int i = 0; i < 5; i++) step(1, 0, 5'd2, "d5to2");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 0, 5'd16, 1, 24'(24'h100000 + i), "wrap16");
      checkOutput();
    end
    for (int i = 0; i < 6; i++) step(1, 0, 5'd31, "sel31");

    step(1, 1, 5'd16, "flush");
    for (int i = 0; i < 17; i++) step(1, 0, 5'd16, "postflush");
    step(0, 1, 5'd16, "flush_noen");
    step(1, 1, 5'd4, "flush_change");
    for (int i = 0; i < 6; i++) step(i != 2, 0, 5'd4, "d4");

`ifdef VAR_DELAY_ZERO_EN
    for (int i = 0; i < 4; i++) step(1, 0, 5'd0, "bypass");
    for (int i = 0; i < 5; i++) step(1, 0, 5'd3, "bypass_to3");
`else
    for (int i = 0; i < 5; i++) step(1, 0, 5'd0, "sel0");
`endif

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 3; i++) step(1, 0, 5'd2, "prereset");
    @(negedge clk);
    resetn = 0;
    #2;
    checkDirect("midreset.out", out_data, 24'h000000);
    checkDirect("midreset.out_valid", 24'(out_valid), 24'h0);
    checkDirect("midreset.primed", 24'(primed), 24'h0);
    resetModel();
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 80; i++) begin
`ifdef VAR_DELAY_ZERO_EN
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
           5'($urandom_range(1, 31)), "random");
`else
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
           5'($urandom_range(0, 31)), "random");
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
